// File: rtl/swap_scheduler.sv
// Node-exchange local-search driver: walks every legal (i,j) pair of the tour, feeds the six
// neighbour coordinates to a checkswap evaluator and swaps tour[i]/tour[j] on an improving verdict.
module swap_scheduler #(
    parameter int N          = 16,
    parameter int IW         = 4,
    parameter int CW         = 32,
    parameter int MAX_PASS   = 8,
    parameter int WAIT_LIMIT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [IW-1:0] coord_addr,
    input  logic [CW-1:0] coord_x,
    input  logic [CW-1:0] coord_y,
    output logic          cs_rst,
    output logic [CW-1:0] cs_x1,
    output logic [CW-1:0] cs_x2,
    output logic [CW-1:0] cs_x3,
    output logic [CW-1:0] cs_x4,
    output logic [CW-1:0] cs_x5,
    output logic [CW-1:0] cs_x6,
    output logic [CW-1:0] cs_y1,
    output logic [CW-1:0] cs_y2,
    output logic [CW-1:0] cs_y3,
    output logic [CW-1:0] cs_y4,
    output logic [CW-1:0] cs_y5,
    output logic [CW-1:0] cs_y6,
    input  logic          cs_res,
    input  logic          cs_complete,
    input  logic [IW-1:0] rd_pos,
    output logic [IW-1:0] rd_city,
    output logic [15:0]   swap_count,
    output logic [7:0]    pass_count,
    output logic [2:0]    dbg_state
);
    // Evaluator handshake: coordinates are stable from KICK until WAIT is left; cs_rst low
    // marks an active evaluation and the first cs_complete seen in WAIT carries the verdict.
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_KICK, S_WAIT, S_APPLY, S_NEXT, S_DONE
    } state_t;

    localparam int WW = $clog2(WAIT_LIMIT + 1);

    state_t        state, state_nxt;
    logic [IW-1:0] tour [N];
    logic [IW-1:0] pi, pj;
    logic [2:0]    fcnt;
    logic [WW-1:0] wcnt;
    logic          verdict, pass_improved;
    logic [CW-1:0] sx [6];
    logic [CW-1:0] sy [6];

    logic [IW-1:0] slot_pos, jmax;
    logic          at_jmax, last_pair, wait_expire, restart;
    logic [7:0]    pc_inc;

    always_comb begin
        case (fcnt)
            3'd0:    slot_pos = (pi == '0) ? IW'(N - 1) : pi - 1'b1;
            3'd1:    slot_pos = pi;
            3'd2:    slot_pos = pi + 1'b1;
            3'd3:    slot_pos = pj - 1'b1;
            3'd4:    slot_pos = pj;
            default: slot_pos = (pj == IW'(N - 1)) ? '0 : pj + 1'b1;
        endcase
    end

    // The wrap-around pair (0,N-1) is excluded, so row 0 stops one column early.
    assign jmax        = (pi == '0) ? IW'(N - 2) : IW'(N - 1);
    assign at_jmax     = (pj == jmax);
    assign last_pair   = at_jmax && (pi == IW'(N - 3));
    assign wait_expire = (wcnt == WW'(WAIT_LIMIT - 1));
    assign pc_inc      = pass_count + 8'd1;
    assign restart     = pass_improved && (int'(pc_inc) < MAX_PASS);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        cs_rst     = 1'b1;
        coord_addr = '0;
        case (state)
            S_IDLE: if (start) state_nxt = S_FETCH;
            S_FETCH: begin
                busy = 1'b1;
                if (fcnt < 3'd6) coord_addr = tour[slot_pos];
                else             state_nxt  = S_KICK;
            end
            S_KICK: begin
                busy      = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy   = 1'b1;
                cs_rst = 1'b0;
                if (cs_complete || wait_expire) state_nxt = S_APPLY;
            end
            S_APPLY: begin
                busy      = 1'b1;
                state_nxt = S_NEXT;
            end
            S_NEXT: begin
                busy      = 1'b1;
                state_nxt = (!last_pair || restart) ? S_FETCH : S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) tour[k] <= IW'(k);
            for (int k = 0; k < 6; k++) begin
                sx[k] <= '0;
                sy[k] <= '0;
            end
            pi            <= '0;
            pj            <= '0;
            fcnt          <= '0;
            wcnt          <= '0;
            verdict       <= 1'b0;
            pass_improved <= 1'b0;
            err           <= 1'b0;
            swap_count    <= '0;
            pass_count    <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    swap_count    <= '0;
                    pass_count    <= '0;
                    err           <= 1'b0;
                    pi            <= '0;
                    pj            <= IW'(2);
                    pass_improved <= 1'b0;
                    fcnt          <= '0;
                end
                S_FETCH: begin
                    fcnt <= fcnt + 3'd1;
                    // ROM answers one cycle late, so slot k lands while slot k+1 is issued.
                    if (fcnt != 3'd0) begin
                        sx[fcnt - 3'd1] <= coord_x;
                        sy[fcnt - 3'd1] <= coord_y;
                    end
                end
                S_KICK: wcnt <= '0;
                S_WAIT: begin
                    wcnt <= wcnt + 1'b1;
                    if (cs_complete) begin
                        verdict <= cs_res;
                    end else if (wait_expire) begin
                        verdict <= 1'b0;
                        err     <= 1'b1;
                    end
                end
                S_APPLY: if (verdict) begin
                    tour[pi]      <= tour[pj];
                    tour[pj]      <= tour[pi];
                    pass_improved <= 1'b1;
                    if (swap_count != 16'hFFFF) swap_count <= swap_count + 16'd1;
                end
                S_NEXT: begin
                    fcnt <= '0;
                    if (!last_pair) begin
                        if (at_jmax) begin
                            pi <= pi + 1'b1;
                            pj <= pi + IW'(3);
                        end else begin
                            pj <= pj + 1'b1;
                        end
                    end else begin
                        pass_count <= pc_inc;
                        if (restart) begin
                            pass_improved <= 1'b0;
                            pi            <= '0;
                            pj            <= IW'(2);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_city   = (int'(rd_pos) < N) ? tour[rd_pos] : '0;
    assign dbg_state = state;
    assign cs_x1 = sx[0];
    assign cs_x2 = sx[1];
    assign cs_x3 = sx[2];
    assign cs_x4 = sx[3];
    assign cs_x5 = sx[4];
    assign cs_x6 = sx[5];
    assign cs_y1 = sy[0];
    assign cs_y2 = sy[1];
    assign cs_y3 = sy[2];
    assign cs_y4 = sy[3];
    assign cs_y5 = sy[4];
    assign cs_y6 = sy[5];
endmodule

// File: tb/tb_swap_scheduler.sv
// Bench for swap_scheduler: three instances (N=6, N=6 with MAX_PASS=3, N=4), each with its own
// coordinate ROM (x=100*city, y=city) and evaluator stub; a tour model predicts every evaluation.
module tb_swap_scheduler;
  localparam int CW = 32;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  logic start_v [NI];
  int   stub_mode [NI];
  int   rd_sel [NI];
  int   total = 0;
  int   bad = 0;

  logic [6*CW-1:0] exp_q[$];
  logic [6*CW-1:0] obs_log [64];
  int m_tour [6];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int GN  = (g == 2) ? 4 : 6;
    localparam int GIW = (g == 2) ? 2 : 3;
    localparam int GMP = (g == 1) ? 3 : 8;

    logic busy, done, err, cs_rst, cs_res, cs_complete, cs_rst_q;
    logic [GIW-1:0] coord_addr, rd_pos, rd_city;
    logic [CW-1:0] coord_x, coord_y;
    logic [CW-1:0] cs_x1, cs_x2, cs_x3, cs_x4, cs_x5, cs_x6;
    logic [CW-1:0] cs_y1, cs_y2, cs_y3, cs_y4, cs_y5, cs_y6;
    logic [15:0] swap_count;
    logic [7:0] pass_count;
    logic [2:0] dbg_state;
    int wcnt = 0;
    int evals = 0;

    assign rd_pos = GIW'(rd_sel[g]);

    swap_scheduler #(.N(GN), .IW(GIW), .CW(CW), .MAX_PASS(GMP), .WAIT_LIMIT(64)) dut (
      .clk(clk), .rst(rst), .start(start_v[g]), .busy(busy), .done(done), .err(err),
      .coord_addr(coord_addr), .coord_x(coord_x), .coord_y(coord_y), .cs_rst(cs_rst),
      .cs_x1(cs_x1), .cs_x2(cs_x2), .cs_x3(cs_x3), .cs_x4(cs_x4), .cs_x5(cs_x5), .cs_x6(cs_x6),
      .cs_y1(cs_y1), .cs_y2(cs_y2), .cs_y3(cs_y3), .cs_y4(cs_y4), .cs_y5(cs_y5), .cs_y6(cs_y6),
      .cs_res(cs_res), .cs_complete(cs_complete), .rd_pos(rd_pos), .rd_city(rd_city),
      .swap_count(swap_count), .pass_count(pass_count), .dbg_state(dbg_state)
    );

    // ROM with one-cycle latency; stub completes 10 cycles after cs_rst falls (mode 3: never).
    always @(posedge clk) begin
      coord_x     <= CW'(100 * int'(coord_addr));
      coord_y     <= CW'(coord_addr);
      cs_rst_q    <= cs_rst;
      cs_complete <= 1'b0;
      cs_res      <= 1'b0;
      if (cs_rst) begin
        wcnt <= 0;
      end else begin
        wcnt <= wcnt + 1;
        if (wcnt == 9 && stub_mode[g] != 3) begin
          cs_complete <= 1'b1;
          cs_res      <= (stub_mode[g] == 2) || (stub_mode[g] == 1 && evals == 1);
        end
      end
      if (start_v[g]) evals <= 0;
      else if (cs_rst_q && !cs_rst) evals <= evals + 1;
    end
  end

  // Reference model of one run on a 6-city tour; optionally pushes expected cs_x1..6 per evaluation.
  task automatic model_run(input int mode, input int maxp, input bit push,
                           output int exp_sw, output int exp_pc);
    int p [6];
    int ev, t, jmax;
    bit imp, v;
    logic [6*CW-1:0] e;
    exp_sw = 0;
    exp_pc = 0;
    ev = 0;
    do begin
      imp = 0;
      for (int i = 0; i < 4; i++) begin
        jmax = (i == 0) ? 4 : 5;
        for (int j = i + 2; j <= jmax; j++) begin
          p[0] = (i + 5) % 6; p[1] = i; p[2] = i + 1;
          p[3] = j - 1; p[4] = j; p[5] = (j + 1) % 6;
          for (int k = 0; k < 6; k++) e[CW*(5-k) +: CW] = CW'(100 * m_tour[p[k]]);
          if (push) exp_q.push_back(e);
          v = (mode == 2) || (mode == 1 && ev == 0);
          ev++;
          if (v) begin
            t = m_tour[i]; m_tour[i] = m_tour[j]; m_tour[j] = t;
            exp_sw++;
            imp = 1;
          end
        end
      end
      exp_pc++;
    end while (imp && exp_pc < maxp);
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk);
    start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
  endtask

  // Runs instance 0 and scoreboards the coordinates presented at each evaluator launch.
  task automatic run0(input int budget, output int n_eval, output int n_done);
    logic prev;
    logic [6*CW-1:0] obs, e;
    int cyc;
    n_eval = 0;
    n_done = 0;
    prev = 1'b1;
    cyc = 0;
    pulse_start(0);
    while (n_done == 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (prev && !gi[0].cs_rst) begin
        obs = {gi[0].cs_x1, gi[0].cs_x2, gi[0].cs_x3, gi[0].cs_x4, gi[0].cs_x5, gi[0].cs_x6};
        if (n_eval < 64) obs_log[n_eval] = obs;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL eval_extra #%0d got %h, none expected", n_eval, obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            bad++;
            $display("FAIL eval_coords #%0d got %h exp %h", n_eval, obs, e);
          end
        end
        n_eval++;
      end
      if (gi[0].done) n_done++;
      prev = gi[0].cs_rst;
    end
    repeat (5) begin
      @(negedge clk);
      if (gi[0].done) n_done++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL eval_missing got %0d left exp 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_other(input int g, input int budget, output int n_done, output int n_wait);
    int cyc;
    logic b, c, d;
    n_done = 0;
    n_wait = 0;
    cyc = 0;
    pulse_start(g);
    while (n_done == 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      b = (g == 1) ? gi[1].busy : gi[2].busy;
      c = (g == 1) ? gi[1].cs_rst : gi[2].cs_rst;
      d = (g == 1) ? gi[1].done : gi[2].done;
      if (b && !c) n_wait++;
      if (d) n_done++;
    end
    repeat (5) begin
      @(negedge clk);
      d = (g == 1) ? gi[1].done : gi[2].done;
      if (d) n_done++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (gi[0].busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b exp 0", gi[0].busy); end
    total++; if (gi[0].done !== 1'b0) begin bad++; $display("FAIL rst_done got %b exp 0", gi[0].done); end
    total++; if (gi[0].err !== 1'b0) begin bad++; $display("FAIL rst_err got %b exp 0", gi[0].err); end
    total++; if (gi[0].cs_rst !== 1'b1) begin bad++; $display("FAIL rst_cs_rst got %b exp 1", gi[0].cs_rst); end
    total++; if (gi[0].coord_addr !== 3'd0) begin bad++; $display("FAIL rst_addr got %0d exp 0", gi[0].coord_addr); end
    total++; if (gi[0].swap_count !== 16'd0 || gi[0].pass_count !== 8'd0) begin
      bad++; $display("FAIL rst_counts got %0d/%0d exp 0/0", gi[0].swap_count, gi[0].pass_count);
    end
    total++; if (gi[0].cs_x1 !== 32'd0 || gi[0].cs_y6 !== 32'd0) begin
      bad++; $display("FAIL rst_cs_xy got %0d/%0d exp 0/0", gi[0].cs_x1, gi[0].cs_y6);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rd_sel[0] = k;
      #1;
      total++;
      if (gi[0].rd_city !== ((k < 6) ? 3'(k) : 3'd0)) begin
        bad++; $display("FAIL rst_rd_city[%0d] got %0d exp %0d", k, gi[0].rd_city, (k < 6) ? k : 0);
      end
    end
    for (int k = 0; k < 6; k++) m_tour[k] = k;
  endtask

  task automatic test_no_swap();
    int n_eval, n_done, sw, pc;
    logic [6*CW-1:0] first_exp;
    stub_mode[0] = 0;
    model_run(0, 8, 1'b1, sw, pc);
    run0(3000, n_eval, n_done);
    first_exp = {32'd500, 32'd0, 32'd100, 32'd100, 32'd200, 32'd300};
    total++; if (obs_log[0] !== first_exp) begin bad++; $display("FAIL first_kick got %h exp %h", obs_log[0], first_exp); end
    total++; if (n_eval != 9) begin bad++; $display("FAIL evals got %0d exp 9", n_eval); end
    total++; if (n_done != 1) begin bad++; $display("FAIL done_pulses got %0d exp 1", n_done); end
    total++; if (gi[0].pass_count !== 8'(pc) || gi[0].swap_count !== 16'(sw)) begin
      bad++; $display("FAIL noswap_counts got %0d/%0d exp %0d/%0d", gi[0].pass_count, gi[0].swap_count, pc, sw);
    end
    total++; if (gi[0].busy !== 1'b0 || gi[0].err !== 1'b0) begin
      bad++; $display("FAIL noswap_idle got busy=%b err=%b exp 0/0", gi[0].busy, gi[0].err);
    end
    for (int k = 0; k < 6; k++) begin
      rd_sel[0] = k;
      #1;
      total++; if (gi[0].rd_city !== 3'(m_tour[k])) begin
        bad++; $display("FAIL noswap_tour[%0d] got %0d exp %0d", k, gi[0].rd_city, m_tour[k]);
      end
    end
  endtask

  task automatic test_single_swap();
    int n_eval, n_done, sw, pc;
    stub_mode[0] = 1;
    model_run(1, 8, 1'b1, sw, pc);
    run0(3000, n_eval, n_done);
    total++; if (obs_log[9][6*CW-1 -: 2*CW] !== {32'd500, 32'd200}) begin
      bad++; $display("FAIL pass2_first got %h exp 500/200", obs_log[9][6*CW-1 -: 2*CW]);
    end
    total++; if (gi[0].pass_count !== 8'd2 || gi[0].swap_count !== 16'd1) begin
      bad++; $display("FAIL swap1_counts got %0d/%0d exp 2/1", gi[0].pass_count, gi[0].swap_count);
    end
    total++; if (n_done != 1) begin bad++; $display("FAIL swap1_done got %0d exp 1", n_done); end
    for (int k = 0; k < 6; k++) begin
      rd_sel[0] = k;
      #1;
      total++; if (gi[0].rd_city !== 3'(m_tour[k])) begin
        bad++; $display("FAIL swap1_tour[%0d] got %0d exp %0d", k, gi[0].rd_city, m_tour[k]);
      end
    end
  endtask

  task automatic test_max_pass();
    int n_done, n_wait, sw, pc;
    for (int k = 0; k < 6; k++) m_tour[k] = k;
    stub_mode[1] = 2;
    model_run(2, 3, 1'b0, sw, pc);
    run_other(1, 4000, n_done, n_wait);
    total++; if (gi[1].pass_count !== 8'd3 || gi[1].swap_count !== 16'd27) begin
      bad++; $display("FAIL maxpass_counts got %0d/%0d exp 3/27", gi[1].pass_count, gi[1].swap_count);
    end
    total++; if (n_done != 1) begin bad++; $display("FAIL maxpass_done got %0d exp 1", n_done); end
    for (int k = 0; k < 6; k++) begin
      rd_sel[1] = k;
      #1;
      total++; if (gi[1].rd_city !== 3'(m_tour[k])) begin
        bad++; $display("FAIL maxpass_tour[%0d] got %0d exp %0d", k, gi[1].rd_city, m_tour[k]);
      end
    end
  endtask

  task automatic test_timeout();
    int n_done, n_wait;
    stub_mode[2] = 3;
    run_other(2, 2000, n_done, n_wait);
    total++; if (n_wait != 128) begin bad++; $display("FAIL timeout_wait got %0d exp 128", n_wait); end
    total++; if (gi[2].err !== 1'b1) begin bad++; $display("FAIL timeout_err got %b exp 1", gi[2].err); end
    total++; if (gi[2].swap_count !== 16'd0 || gi[2].pass_count !== 8'd1) begin
      bad++; $display("FAIL timeout_counts got %0d/%0d exp 0/1", gi[2].swap_count, gi[2].pass_count);
    end
    total++; if (n_done != 1) begin bad++; $display("FAIL timeout_done got %0d exp 1", n_done); end
    for (int k = 0; k < 4; k++) begin
      rd_sel[2] = k;
      #1;
      total++; if (gi[2].rd_city !== 2'(k)) begin
        bad++; $display("FAIL timeout_tour[%0d] got %0d exp %0d", k, gi[2].rd_city, k);
      end
    end
  endtask

  task automatic test_start_rst_mid_wait();
    int cyc, n_done;
    stub_mode[0] = 0;
    pulse_start(0);
    cyc = 0;
    while (gi[0].cs_rst !== 1'b0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    total++; if (cyc >= 100) begin bad++; $display("FAIL reach_wait got timeout exp WAIT within 100"); end
    repeat (2) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    total++; if (gi[0].busy !== 1'b1 || gi[0].cs_rst !== 1'b0) begin
      bad++; $display("FAIL start_ignored got busy=%b cs_rst=%b exp 1/0", gi[0].busy, gi[0].cs_rst);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (gi[0].busy !== 1'b0 || gi[0].cs_rst !== 1'b1 || gi[0].done !== 1'b0) begin
      bad++; $display("FAIL midrst got busy=%b cs_rst=%b done=%b exp 0/1/0", gi[0].busy, gi[0].cs_rst, gi[0].done);
    end
    total++; if (gi[0].swap_count !== 16'd0 || gi[0].pass_count !== 8'd0) begin
      bad++; $display("FAIL midrst_counts got %0d/%0d exp 0/0", gi[0].swap_count, gi[0].pass_count);
    end
    for (int k = 0; k < 6; k++) begin
      rd_sel[0] = k;
      #1;
      total++; if (gi[0].rd_city !== 3'(k)) begin
        bad++; $display("FAIL midrst_tour[%0d] got %0d exp %0d", k, gi[0].rd_city, k);
      end
    end
    n_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (gi[0].done) n_done++;
    end
    total++; if (n_done != 0) begin bad++; $display("FAIL midrst_no_done got %0d exp 0", n_done); end
  endtask

  initial begin
    rst = 1'b1;
    for (int g = 0; g < NI; g++) begin
      start_v[g] = 1'b0;
      stub_mode[g] = 0;
      rd_sel[g] = 0;
    end
    test_reset();
    test_no_swap();
    test_single_swap();
    test_max_pass();
    test_timeout();
    test_start_rst_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
